// File: rtl/gate_recv.sv
// rtl/gate_recv.sv - capability-gated AXI-Stream receive filter with per-port sender permits
// Define GATE_RECV_STATS_EN to build the saturating drop counter; otherwise drop_cnt reads 0.
module gate_recv #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_valid,
  input  logic [13:0]         route_ctrl,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [1:0]          m_axis_tdest,
  output logic                drop_pulse,
  output logic [15:0]         drop_cnt
);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]          r_state;
  logic [N_PORTS-1:0]  r_vld;
  logic [3:0]          r_sid [N_PORTS];
  logic                r_m_tvalid;
  logic [DATA_W-1:0]   r_m_tdata;
  logic [DATA_W/8-1:0] r_m_tkeep;
  logic                r_m_tlast;
  logic [1:0]          r_m_tdest;
  logic                r_drop_pulse;

  logic       w_out_free;
  logic       w_s_hs;
  logic       w_hdr_ok;
  logic       w_fwd;
  logic [1:0] w_hdr_port;
  logic [3:0] w_hdr_sid;
  logic       w_unused_rsvd;

  assign w_unused_rsvd = ^{route_ctrl[12:10], route_ctrl[5:2]};

  assign w_out_free    = !r_m_tvalid || m_axis_tready;
  assign s_axis_tready = (r_state == ST_DROP) ? 1'b1 : w_out_free;
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;
  assign w_hdr_port    = s_axis_tdata[1:0];
  assign w_hdr_sid     = s_axis_tdata[9:6];

  // Header is checked against the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    w_hdr_ok = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_hdr_port == 2'(i) && r_vld[i] && r_sid[i] == w_hdr_sid) begin
        w_hdr_ok = 1'b1;
      end
    end
  end

  assign w_fwd = w_s_hs && (((r_state == ST_HDR) && w_hdr_ok) || (r_state == ST_PASS));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_vld <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        r_sid[i] <= 4'd0;
      end
    end else if (cfg_valid) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (route_ctrl[1:0] == 2'(i)) begin
          r_vld[i] <= !route_ctrl[13];
          if (!route_ctrl[13]) begin
            r_sid[i] <= route_ctrl[9:6];
          end
        end
      end
    end
  end

  // The accept/drop decision is latched in the state, so table edits cannot affect a packet in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_HDR;
    end else if (w_s_hs) begin
      case (r_state)
        ST_HDR: begin
          if (!s_axis_tlast) begin
            r_state <= w_hdr_ok ? ST_PASS : ST_DROP;
          end
        end
        ST_PASS, ST_DROP: begin
          if (s_axis_tlast) begin
            r_state <= ST_HDR;
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tdest  <= 2'd0;
    end else if (w_fwd) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
      r_m_tkeep  <= s_axis_tkeep;
      r_m_tlast  <= s_axis_tlast;
      if (r_state == ST_HDR) begin
        r_m_tdest <= w_hdr_port;
      end
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_s_hs && (r_state == ST_HDR) && !w_hdr_ok;
    end
  end

`ifdef GATE_RECV_STATS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_cnt <= 16'd0;
    end else if (r_drop_pulse && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tdest  = r_m_tdest;
  assign drop_pulse    = r_drop_pulse;

endmodule

// File: tb/tb_gate_recv.sv
// tb/tb_gate_recv.sv - self-checking bench for gate_recv: vector table, directed corners, random vs. model
module tb_gate_recv;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int KW = DW / 8;
`ifdef GATE_RECV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [13:0]   route_ctrl = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tdest;
  logic          drop_pulse;
  logic [15:0]   drop_cnt;

  always #5 aclk = ~aclk;

  gate_recv #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_valid(cfg_valid), .route_ctrl(route_ctrl),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit bp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: permit table, packet-level accept decision, expected egress beats.
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [1:0]    dest;
  } beat_t;

  beat_t      exp_q[$];
  bit         mdl_vld[4];
  logic [3:0] mdl_sid[4];
  bit         in_pkt, cur_acc, exp_pulse, prev_stall;
  logic [1:0] cur_dest;
  int         exp_cnt;
  beat_t      prev_out;

  initial begin
    beat_t b;
    logic [1:0] hp;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin mdl_vld[i] = 0; mdl_sid[i] = 4'd0; end
        in_pkt = 0; cur_acc = 0; exp_pulse = 0; prev_stall = 0; exp_cnt = 0;
      end else begin
        chk("drop_pulse", {63'd0, drop_pulse}, {63'd0, exp_pulse});
        chk("drop_cnt", {48'd0, drop_cnt}, 64'(exp_cnt));
        if (exp_pulse && STATS && exp_cnt < 65535) exp_cnt++;
        exp_pulse = 0;
        if (prev_stall) begin
          chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
          chk("hold_data", m_axis_tdata, prev_out.data);
          chk("hold_ctl", {53'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdest},
              {53'd0, prev_out.keep, prev_out.last, prev_out.dest});
        end
        prev_stall    = m_axis_tvalid && !m_axis_tready;
        prev_out.data = m_axis_tdata;
        prev_out.keep = m_axis_tkeep;
        prev_out.last = m_axis_tlast;
        prev_out.dest = m_axis_tdest;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL out_unexpected: got beat %h expected none at %0t", m_axis_tdata, $time);
          end else begin
            b = exp_q.pop_front();
            chk("out_data", m_axis_tdata, b.data);
            chk("out_ctl", {53'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdest},
                {53'd0, b.keep, b.last, b.dest});
          end
        end
        if (s_axis_tvalid && s_axis_tready) begin
          if (!in_pkt) begin
            hp       = s_axis_tdata[1:0];
            cur_acc  = (int'(hp) < NP) && mdl_vld[hp] && (mdl_sid[hp] == s_axis_tdata[9:6]);
            cur_dest = hp;
            if (!cur_acc) exp_pulse = 1;
          end
          if (cur_acc) begin
            b.data = s_axis_tdata; b.keep = s_axis_tkeep; b.last = s_axis_tlast; b.dest = cur_dest;
            exp_q.push_back(b);
          end
          in_pkt = !s_axis_tlast;
        end
        if (cfg_valid && int'(route_ctrl[1:0]) < NP) begin
          mdl_vld[route_ctrl[1:0]] = !route_ctrl[13];
          if (!route_ctrl[13]) mdl_sid[route_ctrl[1:0]] = route_ctrl[9:6];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (bp_en) m_axis_tready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic set_cfg(input logic [1:0] p, input logic [3:0] sid, input bit rev);
    cfg_valid  = 1'b1;
    route_ctrl = {rev, 3'($urandom), sid, 4'($urandom), p};
  endtask

  task automatic do_cfg(input logic [1:0] p, input logic [3:0] sid, input bit rev);
    set_cfg(p, sid, rev);
    cyc();
    cfg_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [3:0] sid, input logic [1:0] port);
    logic [DW-1:0] d;
    d      = {$urandom, $urandom};
    d[9:6] = sid;
    d[1:0] = port;
    return d;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output int waits);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = KW'($urandom);
    s_axis_tlast  = last;
    waits = 0;
    while (1) begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waits++;
      if (waits > 500) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", waits);
        break;
      end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  typedef struct {
    bit         do_cfg;
    logic [1:0] cp;
    logic [3:0] cs;
    bit         rev;
    logic [1:0] hp;
    logic [3:0] hs;
    bit         acc;
  } vec_t;

  initial begin
    vec_t          vt[10];
    logic [DW-1:0] d[4];
    logic [DW-1:0] hdr;
    int            w;
    int            len;

    vt[0] = '{1'b1, 2'd0, 4'd2,  1'b0, 2'd0, 4'd2,  1'b1};
    vt[1] = '{1'b0, 2'd0, 4'd0,  1'b0, 2'd0, 4'd3,  1'b0};
    vt[2] = '{1'b0, 2'd0, 4'd0,  1'b0, 2'd1, 4'd2,  1'b0};
    vt[3] = '{1'b1, 2'd1, 4'd15, 1'b0, 2'd1, 4'd15, 1'b1};
    vt[4] = '{1'b1, 2'd0, 4'd0,  1'b1, 2'd0, 4'd2,  1'b0};
    vt[5] = '{1'b1, 2'd2, 4'd0,  1'b0, 2'd2, 4'd0,  1'b1};
    vt[6] = '{1'b1, 2'd3, 4'd0,  1'b0, 2'd3, 4'd0,  1'b0};
    vt[7] = '{1'b1, 2'd2, 4'd0,  1'b1, 2'd2, 4'd0,  1'b0};
    vt[8] = '{1'b1, 2'd0, 4'd4,  1'b0, 2'd0, 4'd4,  1'b1};
    vt[9] = '{1'b0, 2'd0, 4'd0,  1'b0, 2'd1, 4'd14, 1'b0};

    repeat (3) cyc();
    @(negedge aclk);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_ctl", {53'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, 64'd0);
    chk("rst_pulse_cnt", {47'd0, drop_pulse, drop_cnt}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    cyc();

    // Single-beat header decisions against the permit table.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].do_cfg) do_cfg(vt[i].cp, vt[i].cs, vt[i].rev);
      send_beat(mk_hdr(vt[i].hs, vt[i].hp), 1'b1, w);
      chk($sformatf("vec%0d_valid", i), {63'd0, m_axis_tvalid}, {63'd0, vt[i].acc});
      chk($sformatf("vec%0d_pulse", i), {63'd0, drop_pulse}, {63'd0, !vt[i].acc});
      if (vt[i].acc) chk($sformatf("vec%0d_dest", i), {62'd0, m_axis_tdest}, {62'd0, vt[i].hp});
      cyc();
    end

    // Accepted 3-beat packet, one-cycle latency, tdest held.
    do_cfg(2'd1, 4'd5, 1'b0);
    d[0] = mk_hdr(4'd5, 2'd1); d[1] = {$urandom, $urandom}; d[2] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      send_beat(d[i], i == 2, w);
      chk($sformatf("acc3_valid%0d", i), {63'd0, m_axis_tvalid}, 64'd1);
      chk($sformatf("acc3_data%0d", i), m_axis_tdata, d[i]);
      chk($sformatf("acc3_dest%0d", i), {62'd0, m_axis_tdest}, 64'd1);
    end
    cyc();

    // Wrong sender: dropped at line rate.
    d[0] = mk_hdr(4'd6, 2'd1);
    for (int i = 0; i < 3; i++) begin
      send_beat(i == 0 ? d[0] : {$urandom, $urandom}, i == 2, w);
      chk($sformatf("drop_ready%0d", i), 64'(w), 64'd0);
      chk($sformatf("drop_valid%0d", i), {63'd0, m_axis_tvalid}, 64'd0);
    end
    repeat (2) cyc();
    chk("drop_cnt_after_drop", {48'd0, drop_cnt}, STATS ? 64'd7 : 64'd0);

    // Config write in the header's own cycle is not yet effective.
    set_cfg(2'd2, 4'd3, 1'b0);
    hdr = mk_hdr(4'd3, 2'd2);
    send_beat(hdr, 1'b1, w);
    cfg_valid = 1'b0;
    chk("samecyc_valid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("samecyc_pulse", {63'd0, drop_pulse}, 64'd1);
    send_beat(hdr, 1'b1, w);
    chk("nextcyc_valid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("nextcyc_data", m_axis_tdata, hdr);
    cyc();

    // Revoke mid-packet leaves the packet intact; the next one is dropped.
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_cfg(2'd1, 4'd0, 1'b1);
      send_beat(i == 0 ? mk_hdr(4'd5, 2'd1) : {$urandom, $urandom}, i == 3, w);
      cfg_valid = 1'b0;
      chk($sformatf("revoke_valid%0d", i), {63'd0, m_axis_tvalid}, 64'd1);
    end
    send_beat(mk_hdr(4'd5, 2'd1), 1'b1, w);
    chk("revoked_valid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("revoked_pulse", {63'd0, drop_pulse}, 64'd1);
    cyc();

    // Egress stall for 5 cycles mid-packet.
    d[0] = mk_hdr(4'd3, 2'd2); d[1] = {$urandom, $urandom};
    d[2] = {$urandom, $urandom}; d[3] = {$urandom, $urandom};
    send_beat(d[0], 1'b0, w);
    send_beat(d[1], 1'b0, w);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d[2]; s_axis_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk($sformatf("stall_sready%0d", i), {63'd0, s_axis_tready}, 64'd0);
      chk($sformatf("stall_valid%0d", i), {63'd0, m_axis_tvalid}, 64'd1);
      chk($sformatf("stall_data%0d", i), m_axis_tdata, d[1]);
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    send_beat(d[2], 1'b0, w);
    chk("stall_resume_data", m_axis_tdata, d[2]);
    send_beat(d[3], 1'b1, w);
    repeat (2) cyc();
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic with concurrent config writes and egress backpressure.
    bp_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if (b == 0) hdr = mk_hdr(4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        else        hdr = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) set_cfg(2'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        send_beat(hdr, b == len - 1, w);
        cfg_valid = 1'b0;
        if ($urandom_range(0, 4) == 0) cyc();
      end
    end
    bp_en = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) cyc();
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // 70000 back-to-back rejected single-beat packets.
    s_axis_tvalid = 1'b1; s_axis_tdata = mk_hdr(4'd0, 2'd3); s_axis_tlast = 1'b1;
    repeat (70000) cyc();
    s_axis_tvalid = 1'b0;
    repeat (3) cyc();
    chk("drop_cnt_sat", {48'd0, drop_cnt}, STATS ? 64'h0000_0000_0000_FFFF : 64'd0);

    // Reset in the middle of an accepted packet.
    do_cfg(2'd0, 4'd9, 1'b0);
    hdr = mk_hdr(4'd9, 2'd0);
    send_beat(hdr, 1'b0, w);
    send_beat({$urandom, $urandom}, 1'b0, w);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("midrst_tdata", m_axis_tdata, 64'd0);
    chk("midrst_ctl", {53'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, 64'd0);
    chk("midrst_pulse_cnt", {47'd0, drop_pulse, drop_cnt}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    send_beat(hdr, 1'b1, w);
    chk("postrst_cleared_valid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("postrst_cleared_pulse", {63'd0, drop_pulse}, 64'd1);
    do_cfg(2'd0, 4'd9, 1'b0);
    send_beat(hdr, 1'b1, w);
    chk("postrst_hdr_valid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("postrst_hdr_data", m_axis_tdata, hdr);
    repeat (3) cyc();
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    chk("final_drop_cnt", {48'd0, drop_cnt}, STATS ? 64'd1 : 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
